// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between a requester and muldiv_unit
//
// Ports (signals carried by the interface):
//   valid_i   requester -> unit  operation request
//   funct3_i  requester -> unit  M-extension op select
//   a_i, b_i  requester -> unit  rs1 / rs2 operands
//   kill_i    requester -> unit  flush of the in-flight op
//   ready_o   unit -> requester  unit idle and able to accept
//   busy_o    unit -> requester  op in flight
//   done_o    unit -> requester  one-cycle completion pulse
//   result_o  unit -> requester  result, held until the next done_o
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            kill_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct3_i, a_i, b_i, kill_i,
    input  ready_o, busy_o, done_o, result_o
  );

  modport slave (
    input  valid_i, funct3_i, a_i, b_i, kill_i,
    output ready_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    muldiv_unit_if slave: valid_i/ready_o handshake, funct3_i, a_i, b_i,
//          kill_i, busy_o, done_o, result_o
// Parameters:
//   XLEN       operand/result width (8..64, even)
//   EARLY_OUT  skip iteration for divide-by-zero and signed overflow
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b;        // raw captured operands
  logic [XLEN-1:0]   r_mcand, r_dvsr; // operand magnitudes
  logic [XLEN-1:0]   r_rem, r_quo;
  logic [2*XLEN-1:0] r_prod;          // {partial high, remaining multiplier bits}
  logic [XLEN-1:0]   r_result;
  logic              r_neg_res, r_neg_rem, r_div0, r_ovf, r_done;

  // Signedness of the captured op: DIV/REM/MULH both signed, MULHSU only rs1.
  logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_div0, w_ovf;
  logic [XLEN-1:0] w_mag_a, w_mag_b;

  assign w_is_div = r_op[2];
  assign w_sgn_a  = w_is_div ? ~r_op[0] : (r_op[1:0] == 2'b01 || r_op[1:0] == 2'b10);
  assign w_sgn_b  = w_is_div ? ~r_op[0] : (r_op[1:0] == 2'b01);
  assign w_neg_a  = w_sgn_a & r_a[XLEN-1];
  assign w_neg_b  = w_sgn_b & r_b[XLEN-1];
  assign w_mag_a  = w_neg_a ? -r_a : r_a;
  assign w_mag_b  = w_neg_b ? -r_b : r_b;
  assign w_div0   = w_is_div && (r_b == '0);
  assign w_ovf    = w_is_div && !r_op[0] && (r_a == MOST_NEG) && (r_b == ALL_ONES);

  // Shift-add step: the extra top bit keeps the carry of the partial sum,
  // which lands in bit 2*XLEN-1 after the right shift.
  logic [XLEN:0] w_sum;
  assign w_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});

  // Restoring divide step: bring in the next dividend bit and try the subtract.
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});
  assign w_diff  = w_shift[XLEN-1:0] - r_dvsr;

  // Sign correction and result selection. The special cases override the
  // iterated values so results are identical with or without EARLY_OUT.
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s, w_fix;
  assign w_prod_s = r_neg_res ? -r_prod : r_prod;
  assign w_quo_s  = r_neg_res ? -r_quo : r_quo;
  assign w_rem_s  = r_neg_rem ? -r_rem : r_rem;

  always_comb begin
    w_fix = '0;
    if (!w_is_div)
      w_fix = (r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    else if (r_div0)
      w_fix = r_op[1] ? r_a : ALL_ONES;
    else if (r_ovf)
      w_fix = r_op[1] ? '0 : MOST_NEG;
    else
      w_fix = r_op[1] ? w_rem_s : w_quo_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_mcand   <= '0;
      r_dvsr    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_prod    <= '0;
      r_result  <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.kill_i) begin
        // Flush: drops any in-flight op and also cancels a same-cycle accept.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.valid_i) begin
              r_op    <= bus.funct3_i;
              r_a     <= bus.a_i;
              r_b     <= bus.b_i;
              r_state <= S_PREP;
            end
          end
          S_PREP: begin
            r_mcand   <= w_mag_a;
            r_dvsr    <= w_mag_b;
            r_prod    <= {{XLEN{1'b0}}, w_mag_b};
            r_quo     <= w_mag_a;
            r_rem     <= '0;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_div0    <= w_div0;
            r_ovf     <= w_ovf;
            r_cnt     <= '0;
            r_state   <= (EARLY_OUT && (w_div0 || w_ovf)) ? S_FIX : S_CALC;
          end
          S_CALC: begin
            // Multiply and divide datapaths both step; FIX picks the right one.
            r_prod <= {w_sum, r_prod[XLEN-1:1]};
            if (w_ge) begin
              r_rem <= w_diff;
              r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(XLEN-1))
              r_state <= S_FIX;
          end
          S_FIX: begin
            r_result <= w_fix;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ready_o  = (r_state == S_IDLE);
  assign bus.busy_o   = (r_state != S_IDLE);
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (XLEN 32 early-out, 32 full, 16)
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit_if #(.XLEN(32)) bus0 ();
  muldiv_unit_if #(.XLEN(32)) bus1 ();
  muldiv_unit_if #(.XLEN(16)) bus2 ();

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u_eo  (.clk(clk), .reset(reset), .bus(bus0));
  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) u_full(.clk(clk), .reset(reset), .bus(bus1));
  muldiv_unit #(.XLEN(16), .EARLY_OUT(1'b1)) u_x16 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return bus0.ready_o;
      1:       return bus1.ready_o;
      default: return bus2.ready_o;
    endcase
  endfunction

  function automatic int qsize();
    return q0.size() + q1.size() + q2.size();
  endfunction

  // Monitor side: pop the oldest expectation for unit d and compare.
  task automatic check_done(input int d, input logic [63:0] act);
    exp_t e;
    int   sz;
    case (d)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_done unit%0d: got result %h expected no done_o", d, act);
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk({e.name, "_result"}, act, e.res);
      chk({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
    end
  endtask

  always @(negedge clk) if (!reset && bus0.done_o) check_done(0, 64'(bus0.result_o));
  always @(negedge clk) if (!reset && bus1.done_o) check_done(1, 64'(bus1.result_o));
  always @(negedge clk) if (!reset && bus2.done_o) check_done(2, 64'(bus2.result_o));

  // Stimulus side: wait for ready, present the op, push the expectation at accept.
  task automatic issue(input int d, input string nm, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input bit push, input bit hold);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!rdy(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_ready_timeout: got ready_o 0 expected 1 within 200 cycles", nm);
    end
    case (d)
      0: begin bus0.funct3_i = f; bus0.a_i = a[31:0]; bus0.b_i = b[31:0]; bus0.valid_i = 1'b1; end
      1: begin bus1.funct3_i = f; bus1.a_i = a[31:0]; bus1.b_i = b[31:0]; bus1.valid_i = 1'b1; end
      default: begin bus2.funct3_i = f; bus2.a_i = a[15:0]; bus2.b_i = b[15:0]; bus2.valid_i = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (push) begin
      e.res = exp; e.lat = lat; e.acc = cyc; e.name = nm;
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    if (!hold) begin
      case (d)
        0:       bus0.valid_i = 1'b0;
        1:       bus1.valid_i = 1'b0;
        default: bus2.valid_i = 1'b0;
      endcase
    end
  endtask

  task automatic drain();
    int n = 0;
    while (qsize() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(qsize()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    bus0.valid_i = 0; bus0.kill_i = 0; bus0.funct3_i = 0; bus0.a_i = 0; bus0.b_i = 0;
    bus1.valid_i = 0; bus1.kill_i = 0; bus1.funct3_i = 0; bus1.a_i = 0; bus1.b_i = 0;
    bus2.valid_i = 0; bus2.kill_i = 0; bus2.funct3_i = 0; bus2.a_i = 0; bus2.b_i = 0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus0.ready_o), 64'd1);
    chk("rst_busy", 64'(bus0.busy_o), 64'd0);
    chk("rst_done", 64'(bus0.done_o), 64'd0);
    chk("rst_result", 64'(bus0.result_o), 64'd0);
    reset = 1'b0;

    // Multiplies, full latency 35 at XLEN=32
    issue(0, "mul_7xm3",   MUL,    64'd7,         64'hFFFFFFFD, 64'hFFFFFFEB, 35, 1, 0);
    issue(0, "mulh_min",   MULH,   64'h80000000,  64'h80000000, 64'h40000000, 35, 1, 0);
    issue(0, "mulhu_max",  MULHU,  64'hFFFFFFFF,  64'hFFFFFFFF, 64'hFFFFFFFE, 35, 1, 0);
    issue(0, "mulhsu_max", MULHSU, 64'hFFFFFFFF,  64'hFFFFFFFF, 64'hFFFFFFFF, 35, 1, 0);
    issue(0, "mul_zero",   MUL,    64'h1234,      64'd0,        64'd0,        35, 1, 0);
    // Divides
    issue(0, "div_m7_2",   DIV,    64'hFFFFFFF9,  64'd2,        64'hFFFFFFFD, 35, 1, 0);
    issue(0, "rem_m7_2",   REM,    64'hFFFFFFF9,  64'd2,        64'hFFFFFFFF, 35, 1, 0);
    issue(0, "divu_100_7", DIVU,   64'd100,       64'd7,        64'd14,       35, 1, 0);
    issue(0, "remu_100_7", REMU,   64'd100,       64'd7,        64'd2,        35, 1, 0);

    // Kill at CALC cycle 10: no done_o, result_o keeps 2
    issue(0, "killed", MUL, 64'd9, 64'd9, 64'd0, 0, 0, 0);
    repeat (11) @(posedge clk);
    #1 bus0.kill_i = 1'b1;
    @(posedge clk);
    #1 bus0.kill_i = 1'b0;
    chk("kill_busy", 64'(bus0.busy_o), 64'd0);
    chk("kill_result_hold", 64'(bus0.result_o), 64'd2);
    repeat (40) @(negedge clk);
    chk("kill_result_later", 64'(bus0.result_o), 64'd2);
    issue(0, "after_kill", DIVU, 64'd1000, 64'd10, 64'd100, 35, 1, 0);

    // Early-out special cases at latency 3
    issue(0, "eo_divu_by0", DIVU, 64'd5,        64'd0,        64'hFFFFFFFF, 3, 1, 0);
    issue(0, "eo_remu_by0", REMU, 64'd5,        64'd0,        64'd5,        3, 1, 0);
    issue(0, "eo_div_ovf",  DIV,  64'h80000000, 64'hFFFFFFFF, 64'h80000000, 3, 1, 0);
    issue(0, "eo_rem_ovf",  REM,  64'h80000000, 64'hFFFFFFFF, 64'd0,        3, 1, 0);
    issue(0, "eo_div_by0",  DIV,  64'hFFFFFFF9, 64'd0,        64'hFFFFFFFF, 3, 1, 0);
    issue(0, "eo_rem_by0",  REM,  64'hFFFFFFF9, 64'd0,        64'hFFFFFFF9, 3, 1, 0);
    drain();

    // kill_i together with valid_i: the accept is cancelled
    @(negedge clk);
    bus0.funct3_i = MUL; bus0.a_i = 32'd2; bus0.b_i = 32'd2;
    bus0.valid_i = 1'b1; bus0.kill_i = 1'b1;
    @(posedge clk);
    #1;
    chk("kill_accept_busy", 64'(bus0.busy_o), 64'd0);
    bus0.valid_i = 1'b0; bus0.kill_i = 1'b0;

    // Back-to-back with valid_i held high: accepts 36 edges apart
    issue(0, "b2b_first",  MUL,  64'd6,  64'd7, 64'd42, 35, 1, 1);
    a1 = last_acc;
    issue(0, "b2b_second", DIVU, 64'd42, 64'd6, 64'd7,  35, 1, 0);
    chk("b2b_interval", 64'(last_acc - a1), 64'd36);

    // EARLY_OUT=0: same special results, full latency
    issue(1, "full_divu_by0", DIVU, 64'd5,        64'd0,        64'hFFFFFFFF, 35, 1, 0);
    issue(1, "full_remu_by0", REMU, 64'd5,        64'd0,        64'd5,        35, 1, 0);
    issue(1, "full_div_ovf",  DIV,  64'h80000000, 64'hFFFFFFFF, 64'h80000000, 35, 1, 0);
    issue(1, "full_rem_ovf",  REM,  64'h80000000, 64'hFFFFFFFF, 64'd0,        35, 1, 0);
    issue(1, "full_div_by0",  DIV,  64'hFFFFFFF9, 64'd0,        64'hFFFFFFFF, 35, 1, 0);
    issue(1, "full_rem_by0",  REM,  64'hFFFFFFF9, 64'd0,        64'hFFFFFFF9, 35, 1, 0);
    issue(1, "full_div_m7_2", DIV,  64'hFFFFFFF9, 64'd2,        64'hFFFFFFFD, 35, 1, 0);

    // XLEN=16: latency 19
    issue(2, "x16_mul",   MUL,   64'h0100, 64'h0100, 64'h0000, 19, 1, 0);
    issue(2, "x16_mulhu", MULHU, 64'h0100, 64'h0100, 64'h0001, 19, 1, 0);
    issue(2, "x16_div",   DIV,   64'hFFF9, 64'd2,    64'hFFFD, 19, 1, 0);
    drain();

    // Reset mid-CALC: op discarded, outputs back to reset values at once
    issue(0, "reset_victim", MUL, 64'd11, 64'd13, 64'd0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(bus0.ready_o), 64'd1);
    chk("midrst_busy", 64'(bus0.busy_o), 64'd0);
    chk("midrst_done", 64'(bus0.done_o), 64'd0);
    chk("midrst_result", 64'(bus0.result_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done_result", 64'(bus0.result_o), 64'd0);
    issue(0, "after_reset", MUL, 64'd3, 64'd5, 64'd15, 35, 1, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, parametrised in operand width, used as the multi-cycle companion to the single-cycle ALU in the CPU datapath.
- Accepts one operation through a valid/ready handshake and computes it with a shift-add multiply or a restoring divide, one bit per cycle.
- Returns the result with a single-cycle done pulse.
- Covers the eight M-extension operations, selected by funct3, with RISC-V-defined results for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width in bits; legal values 8..64, even.
- EARLY_OUT, 1, when 1, divide-by-zero and signed-overflow cases skip the iteration phase.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  operation request.
- ready_o  output  1  unit can accept; high only in IDLE.
- funct3_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  input  XLEN  rs1 operand (multiplicand/dividend).
- b_i  input  XLEN  rs2 operand (multiplier/divisor).
- kill_i  input  1  abort the in-flight op (pipeline flush).
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse; result_o is valid in this cycle.
- result_o  output  XLEN  result; holds its value until the next done_o.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; counter, operand registers and result_o are cleared to 0.
  - Outputs during reset: done_o=0, busy_o=0, ready_o=1.
  - A reset asserted mid-operation discards the op; no done_o follows.
- Accept: on a rising edge with valid_i && ready_o.
  - a_i, b_i and funct3_i are captured; inputs are don't-care afterwards.
  - valid_i is ignored while busy.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
  - IDLE -> PREP on accept.
  - PREP:
    - Takes operand magnitudes and records result sign. Signedness: DIV/REM/MULH both operands signed; MULHSU a signed, b unsigned; MUL and U-ops unsigned.
    - Detects the special cases: divisor==0, and DIV/REM with a==most-negative && b==all-ones.
    - Next state is FIX if EARLY_OUT && special, otherwise CALC with the counter cleared.
  - CALC: exactly XLEN cycles, counter 0..XLEN-1.
    - Multiply: 2*XLEN-bit product register, shift-add, one multiplier bit per cycle.
    - Divide: restoring; remainder/quotient registers, one quotient bit per cycle.
    - Moves to FIX when counter==XLEN-1.
  - FIX:
    - Applies two's-complement sign correction (quotient sign = sa^sb; remainder sign = sign of dividend).
    - Selects the output: MUL = product low half; MULH*/MULHU = high half; DIV* = quotient; REM* = remainder.
    - Writes result_o; next state DONE.
  - DONE: done_o=1 for this cycle only; next state IDLE.
- Latency is counted in edges from the accept edge to the cycle in which done_o is high:
  - Normal ops: XLEN+3 (35 at XLEN=32).
  - Early-out: 3.
  - Initiation interval is latency+1, since ready_o is only high in IDLE.
- Special results (identical whether or not EARLY_OUT is set):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow: DIV gives most-negative; REM gives 0.
- Multiply by zero has no special path and uses the full latency.
- kill_i:
  - In any non-IDLE state, the next state is IDLE; done_o is suppressed and result_o is unchanged.
  - kill_i in the same cycle as an accept cancels that accept: the state stays IDLE.
  - kill_i in DONE has no effect on the done_o already asserted.
- Arithmetic is modulo 2^XLEN on result_o; the internal product is 2*XLEN bits with no truncation before selection.

Test Plan:
- Reset: assert reset mid-CALC -> done_o stays 0; ready_o=1 and result_o=0 immediately; a subsequent op completes normally.
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done_o exactly 35 cycles after accept.
- MULH 0x80000000,0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases with EARLY_OUT=1:
  - DIVU 5/0 -> 0xFFFFFFFF at latency 3.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
  - Repeat with EARLY_OUT=0 -> same values at latency 35.
- kill_i pulsed at CALC cycle 10 -> no done_o; result_o keeps its prior value; next op accepted and correct. Back-to-back valid_i held high -> accepts separated by 36 cycles.
- XLEN=16 build: MUL 0x0100*0x0100 -> 0x0000; MULHU -> 0x0001; latency 19.
